// File: rtl/cube_pkg.sv
// Shared definitions for the voxel cube frame path: geometry, arbiter
// FSM states and the default host starvation bound.
package cube_pkg;

   localparam int VOXEL_ADDR_W         = 12;
   localparam int VOXEL_DATA_W         = 24;
   localparam int DEFAULT_STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      ST_INIT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_SWAP_WAIT = 2'd2
   } arb_state_e;

   // Width of a counter that must be able to hold the value 'limit'.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Bundle of scanner, host and RAM-side signals around the frame arbiter.
// The arbiter uses the slave view; the clients and the RAM use master.
interface frame_buffer_arbiter_if
   import cube_pkg::*;
#(
   parameter int ADDR_W = VOXEL_ADDR_W,
   parameter int DATA_W = VOXEL_DATA_W
) ();

   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;
   logic              scan_gnt;
   logic              scan_rvalid;
   logic [DATA_W-1:0] scan_rdata;
   logic              frame_start;

   logic              host_wr_req;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_wr_ack;
   logic              host_swap_req;

   logic              swap_pending;
   logic              display_bank;
   logic              init_done;

   logic [ADDR_W:0]   ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  scan_req, scan_addr, frame_start,
      input  host_wr_req, host_addr, host_wdata, host_swap_req,
      input  ram_rdata,
      output scan_gnt, scan_rvalid, scan_rdata,
      output host_wr_ack, swap_pending, display_bank, init_done,
      output ram_addr, ram_we, ram_wdata
   );

   modport master (
      output scan_req, scan_addr, frame_start,
      output host_wr_req, host_addr, host_wdata, host_swap_req,
      output ram_rdata,
      input  scan_gnt, scan_rvalid, scan_rdata,
      input  host_wr_ack, swap_pending, display_bank, init_done,
      input  ram_addr, ram_we, ram_wdata
   );

endinterface

// File: rtl/frame_buffer_arbiter_starve_counter.sv
// Saturating count of contended scan grants; at_limit tells the arbiter
// the host has waited long enough and must take the next slot.
module starve_counter
   import cube_pkg::*;
#(
   parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic incr,
   input  logic clr,
   output logic at_limit
);

   localparam int               CNT_W   = cnt_width(LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign at_limit = (count_q == LIMIT_C);

   // Clear wins over increment; the count parks at LIMIT until cleared.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (incr && !at_limit) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Owns the double-banked frame RAM: clears it after reset, then shares the
// single port between scanner reads (front bank) and host writes (back
// bank), and flips banks only on a scanner frame boundary.
module frame_buffer_arbiter
   import cube_pkg::*;
#(
   parameter int ADDR_W       = VOXEL_ADDR_W,
   parameter int DATA_W       = VOXEL_DATA_W,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   frame_buffer_arbiter_if.slave  bus
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
   logic              display_bank_q, display_bank_d;
   logic              swap_pending_q, swap_pending_d;
   logic              init_done_q, init_done_d;
   logic              scan_rvalid_q, scan_rvalid_d;

   logic              host_ok;
   logic              host_gnt;
   logic              scan_gnt;
   logic              contended;
   logic              at_limit;
   logic [ADDR_W:0]   ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;

   starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .reset_n  (reset_n),
      .incr     (contended),
      .clr      (host_gnt),
      .at_limit (at_limit)
   );

   // Same-cycle arbitration: host only competes in RUN, scanner wins ties
   // unless the host has been starved up to the limit.
   always_comb begin
      host_ok   = (state_q == ST_RUN) && bus.host_wr_req;
      host_gnt  = host_ok && (!bus.scan_req || at_limit);
      scan_gnt  = (state_q != ST_INIT) && bus.scan_req && !host_gnt;
      contended = scan_gnt && host_ok;
   end

   // RAM port steering: clear sweep, host write to back bank, or scan read.
   always_comb begin
      ram_addr  = {display_bank_q, bus.scan_addr};
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (state_q == ST_INIT) begin
         ram_addr = clr_addr_q;
         ram_we   = 1'b1;
      end else if (host_gnt) begin
         ram_addr  = {~display_bank_q, bus.host_addr};
         ram_we    = 1'b1;
         ram_wdata = bus.host_wdata;
      end
   end

   // Control FSM next state: clear sweep, run, and wait for frame boundary.
   always_comb begin
      state_d        = state_q;
      clr_addr_d     = clr_addr_q;
      display_bank_d = display_bank_q;
      swap_pending_d = swap_pending_q;
      init_done_d    = init_done_q;
      scan_rvalid_d  = scan_gnt;
      case (state_q)
         ST_INIT: begin
            clr_addr_d = clr_addr_q + (ADDR_W+1)'(1);
            if (&clr_addr_q) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.host_swap_req) begin
               swap_pending_d = 1'b1;
               state_d        = ST_SWAP_WAIT;
            end
         end
         ST_SWAP_WAIT: begin
            if (bus.frame_start) begin
               display_bank_d = ~display_bank_q;
               swap_pending_d = 1'b0;
               state_d        = ST_RUN;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_INIT;
         clr_addr_q     <= '0;
         display_bank_q <= 1'b0;
         swap_pending_q <= 1'b0;
         init_done_q    <= 1'b0;
         scan_rvalid_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         clr_addr_q     <= clr_addr_d;
         display_bank_q <= display_bank_d;
         swap_pending_q <= swap_pending_d;
         init_done_q    <= init_done_d;
         scan_rvalid_q  <= scan_rvalid_d;
      end
   end

   assign bus.scan_gnt     = scan_gnt;
   assign bus.scan_rvalid  = scan_rvalid_q;
   assign bus.scan_rdata   = bus.ram_rdata;
   assign bus.host_wr_ack  = host_gnt;
   assign bus.swap_pending = swap_pending_q;
   assign bus.display_bank = display_bank_q;
   assign bus.init_done    = init_done_q;
   assign bus.ram_addr     = ram_addr;
   assign bus.ram_we       = ram_we;
   assign bus.ram_wdata    = ram_wdata;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: a bank-level reference model
// predicts grants, RAM port activity and read data; a negedge monitor pops
// and compares whatever the DUT presents.
module tb_frame_buffer_arbiter;
   import cube_pkg::*;

   localparam int AW     = 12;
   localparam int DW     = 24;
   localparam int LIMIT  = 8;
   localparam int NWORDS = 8192;
   localparam int HALF   = 4096;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   frame_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   frame_buffer_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // External single-port RAM with one-cycle read latency.
   logic [DW-1:0] mem [NWORDS];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   typedef struct {
      bit            scan_gnt;
      bit            ack;
      bit            bank;
      bit            pend;
      bit            init_done;
      bit            addr_chk;
      logic [AW:0]   addr;
      bit            we;
      logic [DW-1:0] wdata;
   } cyc_rec_t;

   cyc_rec_t      rec_q  [$];
   logic [DW-1:0] read_q [$];
   int vectors     = 0;
   int miscompares = 0;

   // Reference model: bank contents and swap/starvation status.
   bit            m_init;
   int            m_clr;
   bit            m_bank;
   bit            m_pend;
   int            m_losses;
   logic [DW-1:0] ref_mem [2][HALF];

   task automatic model_reset();
      m_init   = 1'b1;
      m_clr    = 0;
      m_bank   = 1'b0;
      m_pend   = 1'b0;
      m_losses = 0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < HALF; a++)
            ref_mem[b][a] = '0;
   endtask

   task automatic drive_idle_inputs();
      bus.scan_req      = 1'b0;
      bus.scan_addr     = '0;
      bus.frame_start   = 1'b0;
      bus.host_wr_req   = 1'b0;
      bus.host_addr     = '0;
      bus.host_wdata    = '0;
      bus.host_swap_req = 1'b0;
   endtask

   // Drive one cycle of inputs, record what the model predicts for it,
   // then advance the model to the next cycle.
   task automatic applyStimulus(input bit sreq, input logic [AW-1:0] saddr,
                                input bit hreq, input logic [AW-1:0] haddr,
                                input logic [DW-1:0] hdata,
                                input bit swap, input bit fstart);
      cyc_rec_t r;
      bit host_ok, hg, sg;
      bus.scan_req      = sreq;
      bus.scan_addr     = saddr;
      bus.host_wr_req   = hreq;
      bus.host_addr     = haddr;
      bus.host_wdata    = hdata;
      bus.host_swap_req = swap;
      bus.frame_start   = fstart;
      r = '{default: '0};
      r.bank      = m_bank;
      r.pend      = m_pend;
      r.init_done = !m_init;
      if (m_init) begin
         r.addr_chk = 1'b1;
         r.addr     = (AW+1)'(m_clr);
         r.we       = 1'b1;
         r.wdata    = '0;
         m_clr++;
         if (m_clr == NWORDS) m_init = 1'b0;
      end else begin
         host_ok = hreq && !m_pend;
         hg = host_ok && (!sreq || m_losses == LIMIT);
         sg = sreq && !hg;
         if (hg) begin
            r.ack      = 1'b1;
            r.addr_chk = 1'b1;
            r.addr     = {~m_bank, haddr};
            r.we       = 1'b1;
            r.wdata    = hdata;
            ref_mem[~m_bank][haddr] = hdata;
            m_losses = 0;
         end else if (sg) begin
            r.scan_gnt = 1'b1;
            r.addr_chk = 1'b1;
            r.addr     = {m_bank, saddr};
            read_q.push_back(ref_mem[m_bank][saddr]);
            if (host_ok && m_losses < LIMIT) m_losses++;
         end
         if (!m_pend && swap) begin
            m_pend = 1'b1;
         end else if (m_pend && fstart) begin
            m_bank = ~m_bank;
            m_pend = 1'b0;
         end
      end
      rec_q.push_back(r);
      @(posedge clk);
      #1;
   endtask

   task automatic applyRandom(input int n, input bit with_frames);
      for (int i = 0; i < n; i++) begin
         applyStimulus($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)),
                       $urandom_range(0, 99) < 50, AW'($urandom_range(0, 7)),
                       DW'($urandom), with_frames && ($urandom_range(0, 99) < 4),
                       with_frames && ($urandom_range(0, 99) < 4));
      end
   endtask

   task automatic checkOutput(input cyc_rec_t r);
      bit bad;
      vectors++;
      bad = (bus.scan_gnt !== r.scan_gnt) || (bus.host_wr_ack !== r.ack) ||
            (bus.display_bank !== r.bank) || (bus.swap_pending !== r.pend) ||
            (bus.init_done !== r.init_done) || (bus.ram_we !== r.we);
      if (r.addr_chk && (bus.ram_addr !== r.addr)) bad = 1'b1;
      if (r.we && (bus.ram_wdata !== r.wdata)) bad = 1'b1;
      if (bad) begin
         miscompares++;
         $display("[TB] FAIL cycle @%0t: got gnt=%b ack=%b bank=%b pend=%b done=%b we=%b addr=%h wdata=%h, want gnt=%b ack=%b bank=%b pend=%b done=%b we=%b addr=%h(chk=%b) wdata=%h",
                  $time, bus.scan_gnt, bus.host_wr_ack, bus.display_bank, bus.swap_pending,
                  bus.init_done, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                  r.scan_gnt, r.ack, r.bank, r.pend, r.init_done, r.we, r.addr, r.addr_chk, r.wdata);
      end
   endtask

   task automatic checkReset(input string name);
      vectors++;
      if (bus.display_bank !== 1'b0 || bus.swap_pending !== 1'b0 || bus.init_done !== 1'b0 ||
          bus.scan_rvalid !== 1'b0 || bus.scan_gnt !== 1'b0 || bus.host_wr_ack !== 1'b0 ||
          bus.ram_addr !== '0 || bus.ram_we !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s: got bank=%b pend=%b done=%b rvalid=%b gnt=%b ack=%b addr=%h we=%b, want 0 0 0 0 0 0 0000 1",
                  name, bus.display_bank, bus.swap_pending, bus.init_done, bus.scan_rvalid,
                  bus.scan_gnt, bus.host_wr_ack, bus.ram_addr, bus.ram_we);
      end
   endtask

   // Monitor: per-cycle record check plus read-data scoreboard.
   always @(negedge clk) begin
      cyc_rec_t      r;
      logic [DW-1:0] exp_data;
      if (rec_q.size() > 0) begin
         r = rec_q.pop_front();
         checkOutput(r);
      end
      if (bus.scan_rvalid === 1'b1) begin
         vectors++;
         if (read_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL rvalid @%0t: got scan_rvalid=1, want no read outstanding", $time);
         end else begin
            exp_data = read_q.pop_front();
            if (bus.scan_rdata !== exp_data) begin
               miscompares++;
               $display("[TB] FAIL rdata @%0t: got %h, want %h", $time, bus.scan_rdata, exp_data);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      drive_idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checkReset("reset_state");
      reset_n = 1'b1;

      // Clear sweep with requests and dropped swap pulses arriving meanwhile.
      applyRandom(NWORDS, 1'b1);

      // Host-only write lands in back bank 1.
      applyStimulus(1'b0, '0, 1'b1, 12'h123, 24'hFF0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 12'h123, 1'b0, '0, '0, 1'b0, 1'b0);

      // Continuous contention: eight scan grants then one host grant.
      for (int i = 0; i < 27; i++)
         applyStimulus(1'b1, AW'(i % 8), 1'b1, AW'(i % 8), DW'($urandom), 1'b0, 1'b0);

      // Swap request alongside a write, blocked writes, then frame boundary.
      applyStimulus(1'b0, '0, 1'b1, 12'h005, 24'h00AA55, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus(i[0], 12'h123, 1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 12'h123, 1'b1, 12'h006, 24'h123456, 1'b0, 1'b1);
      applyStimulus(1'b1, 12'h123, 1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 12'h007, 24'h0000FF, 1'b0, 1'b0);

      // Swap request coincident with frame_start: latched, flips next frame.
      applyStimulus(1'b1, 12'h005, 1'b0, '0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 12'h005, 1'b1, 12'h008, DW'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 12'h007, 1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b1, 12'h007, 1'b0, '0, '0, 1'b0, 1'b0);

      applyRandom(1500, 1'b1);

      // Bring display bank to 1 and park in swap wait, then reset.
      if (m_pend) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (!m_bank) begin
         applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
         applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      applyStimulus(1'b1, 12'h001, 1'b1, 12'h002, 24'h0F0F0F, 1'b1, 1'b0);
      applyStimulus(1'b1, 12'h001, 1'b1, 12'h002, 24'h0F0F0F, 1'b0, 1'b0);
      drive_idle_inputs();
      reset_n = 1'b0;
      #2;
      checkReset("midrun_reset");
      rec_q.delete();
      read_q.delete();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      applyRandom(NWORDS, 1'b1);
      applyRandom(200, 1'b1);
      drive_idle_inputs();

      @(negedge clk);
      #1;
      vectors++;
      if (read_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL read_drain: got %0d reads still outstanding, want 0", read_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

- Arbitrates one single-port, double-banked frame RAM (2 × 4096 voxels × 24-bit RGB) between the real-time scan controller (reads) and the host frame loader (writes).
- Owns the bank-swap handshake: host-completed frames become visible only at a scan frame boundary, so the cube never displays a torn frame.
- Clears both banks after reset, before either side is served.
- Sits between the host interface logic and `controller`, replacing direct RAM ownership.

## Interface
- `ADDR_W`, 12: voxel address width (4096 voxels per bank).
- `DATA_W`, 24: voxel word, {R[7:0], G[7:0], B[7:0]}.
- `STARVE_LIMIT`, 8: consecutive contended scan grants before the host is forced one slot (≥1).
- `clk` in 1: system clock (50 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_req` in 1: scanner read request.
- `scan_addr` in ADDR_W: scanner voxel address.
- `scan_gnt` out 1: read accepted this cycle.
- `scan_rvalid` out 1: `scan_rdata` valid; registered, one cycle after `scan_gnt`.
- `scan_rdata` out DATA_W: passthrough of `ram_rdata`.
- `frame_start` in 1: one-cycle pulse from the scanner, one cycle before its first read of a frame.
- `host_wr_req` in 1: host write request.
- `host_addr` in ADDR_W: host write address.
- `host_wdata` in DATA_W: host write data.
- `host_wr_ack` out 1: write performed at this edge.
- `host_swap_req` in 1: pulse meaning the back buffer is complete.
- `swap_pending` out 1: swap requested, not yet executed.
- `display_bank` out 1: bank currently scanned.
- `init_done` out 1: post-reset clear complete.
- `ram_addr` out ADDR_W+1: {bank, voxel address}.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, 1-cycle latency.

## Operation
- Control FSM states: INIT, RUN, SWAP_WAIT.
- INIT:
  - Sequential clear of addresses 0…2^(ADDR_W+1)−1 with `ram_we`=1 and `ram_wdata`=0, one address per cycle.
  - `scan_gnt`=`host_wr_ack`=0.
  - After the last address: `init_done`=1, go to RUN.
  - `host_swap_req` pulses arriving during INIT are dropped.
- RUN: arbitration each cycle, combinational from the requests and registered state.
  - Only `scan_req`: grant the scanner. `ram_addr`={`display_bank`, `scan_addr`}, `ram_we`=0.
  - Only `host_wr_req`: grant the host. `ram_addr`={~`display_bank`, `host_addr`}, `ram_we`=1.
  - Both: the scanner wins unless `starve_cnt`==STARVE_LIMIT, in which case the host wins.
  - `starve_cnt` increments on each contended scan grant, saturates at STARVE_LIMIT, and clears on any host grant.
- RUN, `host_swap_req`=1: `swap_pending`←1, go to SWAP_WAIT.
- SWAP_WAIT:
  - Host writes are blocked (`host_wr_ack`=0), so writes cannot leak into the bank about to be displayed.
  - The scanner is served as in RUN.
  - On `frame_start`: `display_bank`←~`display_bank`, `swap_pending`←0, go to RUN.
- Extra `host_swap_req` pulses while pending are ignored; no double swap.
- `frame_start` without a pending swap: no effect.

## Timing
- Reset values:
  - State INIT, clear address 0.
  - `display_bank`=0, `swap_pending`=0, `init_done`=0, `scan_rvalid`=0, `starve_cnt`=0.
  - `scan_gnt`=0, `host_wr_ack`=0.
  - `ram_we`=1 from the first cycle after reset release.
- Clear duration: 2^(ADDR_W+1) cycles (8192). `init_done` rises on the cycle after the last clear write.
- Grants and acks are same-cycle (combinational). The write commits at that edge. Read data arrives with `scan_rvalid` on the next cycle.
- Swap edge: reads granted in the `frame_start` cycle use the old bank. The first cycle after it uses the new bank.
- `host_swap_req` in the same cycle as `frame_start`, with nothing pending: latched only; the swap executes at the next `frame_start`.
- `host_swap_req` in the same cycle as a host write: the write is acked (still RUN) and the swap is then pending.
- `reset_n` low mid-operation: all state returns to reset values immediately; the clear restarts from address 0.

## Structure
- Shared package `cube_pkg`:
  - `VOXEL_ADDR_W`=12 and `VOXEL_DATA_W`=24.
  - The FSM state enum (INIT/RUN/SWAP_WAIT).
  - Default STARVE_LIMIT.
- Natural sub-module: `starve_counter`, a saturating counter with an increment/clear interface and an `at_limit` output.
- The RAM itself is external, not instantiated here.

## Test plan
- Reset release: 8192 cycles of `ram_we`=1, `ram_wdata`=0 with the address sweeping 0→8191; `init_done`=1 at cycle 8192; no grants before that.
- Host-only write of addr 0x123, data 0xFF0000: `host_wr_ack`=1 same cycle, `ram_addr`=0x1123 (back bank 1), `ram_we`=1.
- `scan_req` and `host_wr_req` held continuously with STARVE_LIMIT=8: 8 scan grants, then 1 host grant, repeating; `scan_rvalid` follows each scan grant by 1 cycle.
- `host_swap_req`, then host writes: `swap_pending`=1, `host_wr_ack`=0 until `frame_start`; `display_bank` 0→1 the next cycle; writes then resume to bank 0.
- `host_swap_req` coincident with `frame_start`: `display_bank` unchanged; it flips only at the following `frame_start`.
- `reset_n` pulsed low during SWAP_WAIT with `display_bank`=1: `display_bank`=0, `swap_pending`=0, `init_done`=0, clear restarts at address 0.
